// File: rtl/vram_read_arbiter.sv
// vram_read_arbiter: shares the VRAM read port between display fetch (absolute priority) and host reads
module vram_read_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  input  logic              dispTag,
  output logic              dispValid,
  output logic [DATA_W-1:0] dispData,
  output logic              dispTagOut,
  input  logic              hostRdReq,
  input  logic [ADDR_W-1:0] hostRdAddr,
  output logic              hostRdBusy,
  output logic              hostRdAck,
  output logic [DATA_W-1:0] hostRdData,
  input  logic              vramWr,
  input  logic [ADDR_W-1:0] vramWrAddr,
  input  logic [DATA_W-1:0] vramWrData,
  output logic              hostStarve,
  input  logic              hostStarveClr,
  output logic [ADDR_W-1:0] readoutAddr,
  input  logic [DATA_W-1:0] readoutData
);
  typedef enum logic [1:0] {IDLE, PEND, DATA} state_t;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] host_addr;
  logic [CNT_W-1:0]  cnt;
  logic              fwd_hit, disp_valid, disp_tag, issue, stall, accept;
  logic [DATA_W-1:0] fwd_data, held, host_word;
  always_comb begin
    issue       = state == PEND && !dispReq;
    stall       = state == PEND && dispReq;
    accept      = state == IDLE && hostRdReq;
    state_nxt   = accept ? PEND : issue ? DATA : state == DATA ? IDLE : state;
    readoutAddr = (dispReq || state != PEND) ? dispAddr : host_addr;
    host_word   = fwd_hit ? fwd_data : readoutData;
    hostRdAck   = state == DATA;
    hostRdBusy  = state != IDLE;
    hostRdData  = hostRdAck ? host_word : held;
    dispValid   = disp_valid;
    dispData    = disp_valid ? readoutData : '0;
    dispTagOut  = disp_tag;
  end
  // the VRAM is read-first, so a write landing in the issue cycle must be forwarded
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      host_addr  <= '0;
      cnt        <= '0;
      fwd_hit    <= 1'b0;
      fwd_data   <= '0;
      held       <= '0;
      disp_valid <= 1'b0;
      disp_tag   <= 1'b0;
      hostStarve <= 1'b0;
    end else begin
      state      <= state_nxt;
      disp_valid <= dispReq;
      if (dispReq) disp_tag <= dispTag;
      if (accept) begin
        host_addr <= hostRdAddr;
        cnt       <= '0;
      end else if (stall && cnt != '1) cnt <= cnt + 1'b1;
      if (issue) begin
        fwd_hit  <= vramWr && vramWrAddr == host_addr;
        fwd_data <= vramWrData;
      end
      if (hostRdAck) held <= host_word;
      hostStarve <= (stall && cnt >= CNT_W'(STARVE_LIMIT - 2)) || (hostStarve && !hostStarveClr);
    end
  end
endmodule
